vertex_sequencer: RTL and testbench

VERTEX_SEQUENCER -- requirements
Module: vertex_sequencer

---
 rtl/vp_pkg.sv | 22 ++
 rtl/vp_run_counter.sv | 44 ++++
 rtl/vertex_sequencer.sv | 140 ++++++++++++++
 tb/tb_vertex_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared definitions for the vertex sequencer: default widths, info-memory
// slot constants and the sequencer state encoding.
package vp_pkg;

    localparam int VP_INFO_W      = 128;
    localparam int VP_INFO_ADDR_W = 8;
    localparam int VP_PROG_W      = 8;

    localparam logic [VP_INFO_ADDR_W-1:0] VP_IN_ADDR  = 8'd0;
    localparam logic [VP_INFO_ADDR_W-1:0] VP_OUT_ADDR = 8'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PCRST = 3'd2,
        ST_RUN   = 3'd3,
        ST_READ  = 3'd4,
        ST_CAPT  = 3'd5,
        ST_OUT   = 3'd6
    } vp_state_e;

endpackage

// File: rtl/vp_run_counter.sv
// Down-counter for the processor run cycles of one vertex. Loads the program
// length, counts down by one per enabled cycle and never wraps below zero.
module vp_run_counter
    import vp_pkg::*;
#(
    parameter int PROG_W = VP_PROG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [PROG_W-1:0] load_val,
    input  logic              dec,
    output logic [PROG_W-1:0] count,
    output logic              last
);

    localparam logic [PROG_W-1:0] ONE = PROG_W'(1);

    logic [PROG_W-1:0] cnt_q;
    logic [PROG_W-1:0] cnt_d;

    // Next count: a load wins, otherwise decrement only while non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register, cleared by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign last  = (cnt_q == ONE);

endmodule

// File: rtl/vertex_sequencer.sv
// Vertex sequencer: accepts one vertex, writes it into the processor info
// memory, pulses the processor PC reset, runs the processor for prog_len
// cycles, reads the result slot back and offers it downstream.
module vertex_sequencer
    import vp_pkg::*;
#(
    parameter int                     INFO_W      = VP_INFO_W,
    parameter int                     INFO_ADDR_W = VP_INFO_ADDR_W,
    parameter int                     PROG_W      = VP_PROG_W,
    parameter logic [INFO_ADDR_W-1:0] IN_ADDR     = VP_IN_ADDR,
    parameter logic [INFO_ADDR_W-1:0] OUT_ADDR    = VP_OUT_ADDR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [INFO_W-1:0]      s_vertex,
    input  logic [PROG_W-1:0]      prog_len,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [INFO_W-1:0]      m_vertex,
    output logic                   vp_enable,
    output logic                   vp_reset,
    output logic                   vp_we_inf,
    output logic [INFO_ADDR_W-1:0] vp_addr_inf,
    output logic [INFO_W-1:0]      vp_info_in,
    input  logic [INFO_W-1:0]      vp_vert_out,
    output logic                   busy,
    output logic [15:0]            vert_count
);

    vp_state_e         state_q;
    vp_state_e         state_d;
    logic [INFO_W-1:0] vtx_q;
    logic [INFO_W-1:0] vtx_d;
    logic [INFO_W-1:0] m_vertex_q;
    logic [INFO_W-1:0] m_vertex_d;
    logic [15:0]       vert_count_q;
    logic [15:0]       vert_count_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic [PROG_W-1:0] run_cnt;
    logic              run_last;

    vp_run_counter #(
        .PROG_W (PROG_W)
    ) u_run_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (prog_len),
        .dec      (cnt_dec),
        .count    (run_cnt),
        .last     (run_last)
    );

    // Next-state and output decode; every output is a pure function of the
    // current state so the reset state drives idle values immediately.
    always_comb begin
        state_d      = state_q;
        vtx_d        = vtx_q;
        m_vertex_d   = m_vertex_q;
        vert_count_d = vert_count_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        vp_enable    = 1'b0;
        vp_reset     = 1'b0;
        vp_we_inf    = 1'b0;
        vp_addr_inf  = IN_ADDR;
        vp_info_in   = vtx_q;

        case (state_q)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    vtx_d    = s_vertex;
                    cnt_load = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                vp_we_inf = 1'b1;
                state_d   = ST_PCRST;
            end
            ST_PCRST: begin
                vp_reset = 1'b1;
                state_d  = (run_cnt != '0) ? ST_RUN : ST_READ;
            end
            ST_RUN: begin
                vp_enable = 1'b1;
                cnt_dec   = 1'b1;
                if (run_last) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                vp_addr_inf = OUT_ADDR;
                state_d     = ST_CAPT;
            end
            ST_CAPT: begin
                vp_addr_inf = OUT_ADDR;
                m_vertex_d  = vp_vert_out;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    vert_count_d = vert_count_q + 16'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, discarded by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            vtx_q        <= '0;
            m_vertex_q   <= '0;
            vert_count_q <= '0;
        end else begin
            state_q      <= state_d;
            vtx_q        <= vtx_d;
            m_vertex_q   <= m_vertex_d;
            vert_count_q <= vert_count_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign m_vertex   = m_vertex_q;
    assign vert_count = vert_count_q;

endmodule

// File: tb/tb_vertex_sequencer.sv
// Self-checking bench for vertex_sequencer: directed scenarios plus random
// vertices, checked against a transaction-level reference model.
module tb_vertex_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_vertex;
    logic [7:0]   prog_len;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_vertex;
    logic         vp_enable;
    logic         vp_reset;
    logic         vp_we_inf;
    logic [7:0]   vp_addr_inf;
    logic [127:0] vp_info_in;
    logic [127:0] vp_vert_out;
    logic         busy;
    logic [15:0]  vert_count;

    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    logic [15:0]  modelCount;
    logic [127:0] infoMem [0:255];

    vertex_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_vertex    (s_vertex),
        .prog_len    (prog_len),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_vertex    (m_vertex),
        .vp_enable   (vp_enable),
        .vp_reset    (vp_reset),
        .vp_we_inf   (vp_we_inf),
        .vp_addr_inf (vp_addr_inf),
        .vp_info_in  (vp_info_in),
        .vp_vert_out (vp_vert_out),
        .busy        (busy),
        .vert_count  (vert_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Posedge counter used to measure latency in clock edges
    always @(posedge clk) cyc <= cyc + 1;

    // Processor and info-memory stand-in: PC reset copies ~slot0 into slot1,
    // each enabled cycle adds one to slot1; reads are registered.
    always @(posedge clk) begin
        if (vp_we_inf) infoMem[vp_addr_inf] <= vp_info_in;
        if (vp_reset) infoMem[1] <= ~infoMem[0];
        else if (vp_enable) infoMem[1] <= infoMem[1] + 128'd1;
        vp_vert_out <= infoMem[vp_addr_inf];
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push one vertex through and check it against the reference model:
    // one write of the vertex to slot 0, n enabled cycles, result ~v + n,
    // handshake offered at accept+5+n, count incremented on completion.
    task automatic applyStimulus(input logic [127:0] vtx, input int n, input int bp, input bit pokePcrst);
        int guard, acceptEdge, enCount, wrCount, wrBad, readyViol, stableViol, lat;
        logic [127:0] expResult, held;
        bit seen;
        expResult = ~vtx + 128'(n);
        guard = 0;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("idle_ready", 128'(s_ready), 128'd1);
        s_valid    = 1'b1;
        s_vertex   = vtx;
        prog_len   = 8'(n);
        acceptEdge = cyc + 1;
        @(negedge clk);
        s_valid  = 1'b0;
        prog_len = 8'($urandom);
        s_vertex = {$urandom, $urandom, $urandom, $urandom};
        checkOutput("busy_after_accept", 128'(busy), 128'd1);
        enCount = 0; wrCount = 0; wrBad = 0; readyViol = 0; lat = 0; seen = 1'b0;
        for (guard = 0; guard < 400 && !seen; guard++) begin
            if (guard > 0) @(negedge clk);
            if (pokePcrst) s_valid = vp_reset;
            if (vp_enable) enCount++;
            if (vp_we_inf) begin
                wrCount++;
                if (vp_addr_inf !== 8'd0 || vp_info_in !== vtx) wrBad++;
            end
            if (s_ready) readyViol++;
            if (m_valid) begin
                seen = 1'b1;
                lat  = cyc + 1 - acceptEdge;
            end
        end
        s_valid = 1'b0;
        if (!seen) begin
            checkOutput("mvalid_timeout", 128'd0, 128'd1);
            return;
        end
        checkOutput("load_writes", 128'(wrCount), 128'd1);
        checkOutput("load_addr_data", 128'(wrBad), 128'd0);
        checkOutput("enable_cycles", 128'(enCount), 128'(n));
        checkOutput("latency", 128'(lat), 128'(5 + n));
        checkOutput("ready_in_flight", 128'(readyViol), 128'd0);
        checkOutput("result", m_vertex, expResult);
        held = m_vertex;
        stableViol = 0;
        for (int i = 0; i < bp; i++) begin
            m_ready = 1'b0;
            @(negedge clk);
            if (!m_valid || m_vertex !== held || s_ready) stableViol++;
        end
        if (bp > 0) checkOutput("backpressure_hold", 128'(stableViol), 128'd0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        modelCount = modelCount + 16'd1;
        checkOutput("mvalid_drop", 128'(m_valid), 128'd0);
        checkOutput("vert_count", 128'(vert_count), 128'(modelCount));
        checkOutput("back_idle", 128'(s_ready), 128'd1);
    endtask

    // Check every output against its reset value
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mvalid"}, 128'(m_valid), 128'd0);
        checkOutput({tag, "_enable"}, 128'(vp_enable), 128'd0);
        checkOutput({tag, "_vpreset"}, 128'(vp_reset), 128'd0);
        checkOutput({tag, "_we"}, 128'(vp_we_inf), 128'd0);
        checkOutput({tag, "_addr"}, 128'(vp_addr_inf), 128'd0);
        checkOutput({tag, "_busy"}, 128'(busy), 128'd0);
        checkOutput({tag, "_mvertex"}, m_vertex, 128'd0);
        checkOutput({tag, "_count"}, 128'(vert_count), 128'd0);
        checkOutput({tag, "_info_in"}, vp_info_in, 128'd0);
        checkOutput({tag, "_sready"}, 128'(s_ready), 128'd1);
    endtask

    // Main sequence of directed and random scenarios
    initial begin
        int guard, enCount;
        bit sawValid;
        reset      = 1'b0;
        s_valid    = 1'b0;
        s_vertex   = '0;
        prog_len   = '0;
        m_ready    = 1'b0;
        modelCount = '0;
        repeat (3) @(negedge clk);
        checkResetValues("por");
        reset = 1'b1;

        $display("[TB] basic");
        applyStimulus(128'h0001_0002_0003_0004, 4, 0, 1'b0);
        $display("[TB] zero length");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0);
        $display("[TB] backpressure");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 3, 10, 1'b0);
        $display("[TB] ignored input during PCRST");
        applyStimulus(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 2, 1, 1'b1);
        applyStimulus(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 0, 1'b1);

        $display("[TB] random");
        for (int k = 0; k < 15; k++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom},
                          int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        $display("[TB] reset mid-run");
        s_valid  = 1'b1;
        s_vertex = {$urandom, $urandom, $urandom, $urandom};
        prog_len = 8'd8;
        @(negedge clk);
        s_valid  = 1'b0;
        enCount  = 0;
        sawValid = 1'b0;
        for (guard = 0; guard < 50 && enCount < 2; guard++) begin
            @(negedge clk);
            if (vp_enable) enCount++;
            if (m_valid) sawValid = 1'b1;
        end
        checkOutput("reached_run2", 128'(enCount), 128'd2);
        reset = 1'b0;
        #1;
        checkResetValues("midrun");
        modelCount = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m_valid) sawValid = 1'b1;
        end
        checkOutput("no_partial_mvalid", 128'(sawValid), 128'd0);
        reset = 1'b1;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 5, 0, 1'b0);

        $display("[TB] max length and wrap");
        force dut.vert_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.vert_count_q;
        @(negedge clk);
        modelCount = 16'hFFFF;
        checkOutput("count_preload", 128'(vert_count), 128'hFFFF);
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 255, 2, 1'b0);
        checkOutput("count_wrapped", 128'(vert_count), 128'd0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
